// File: rtl/level_status_tracker_if.sv
// ---------------------------------------------------------------------------
// level_status_tracker_if
//
// Bundles the signals exchanged between gameplay, the level/screen manager
// and the level status tracker.
//
//   one_sec         tick once per second, one clk wide
//   hazard_hit      pulse, player touched a hazard
//   item_collected  pulse, player collected an item
//   lvl[2:0]        current level index from the manager
//   reset_fsm_N     low while the manager shows a win/died screen
//   bumpy_died      death event, held until acknowledged
//   level_comp      level-complete event, held until acknowledged
//   zero_lives      sticky once lives reach 0
//   lives[1:0]      remaining lives
//   items_left[3:0] items still required this level
//   time_left[6:0]  seconds remaining this level
//
// master : drives the gameplay pulses and manager inputs, reads status
// slave  : the tracker itself
// ---------------------------------------------------------------------------
interface level_status_tracker_if;
    logic       one_sec;
    logic       hazard_hit;
    logic       item_collected;
    logic [2:0] lvl;
    logic       reset_fsm_N;
    logic       bumpy_died;
    logic       level_comp;
    logic       zero_lives;
    logic [1:0] lives;
    logic [3:0] items_left;
    logic [6:0] time_left;

    modport master (
        output one_sec, hazard_hit, item_collected, lvl, reset_fsm_N,
        input  bumpy_died, level_comp, zero_lives, lives, items_left, time_left
    );

    modport slave (
        input  one_sec, hazard_hit, item_collected, lvl, reset_fsm_N,
        output bumpy_died, level_comp, zero_lives, lives, items_left, time_left
    );
endinterface

// File: rtl/level_status_tracker.sv
// ---------------------------------------------------------------------------
// level_status_tracker
//
// Gameplay-side producer of the per-level status events. Counts collected
// items against a per-level quota, runs a per-level countdown and tracks
// lives. A level-complete or death event is raised and held until the
// manager acknowledges it by pulling reset_fsm_N low; when reset_fsm_N
// returns high the level is re-armed (or the game ends when out of lives).
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    level_status_tracker_if.slave (pulses in, status out)
//
// Parameters:
//   INIT_LIVES      lives at reset (1..3)
//   BASE_ITEMS      items required at level 0; quota = BASE_ITEMS + lvl
//   LEVEL_TIME_SEC  per-level countdown in seconds (1..127)
// ---------------------------------------------------------------------------
module level_status_tracker #(
    parameter int INIT_LIVES     = 3,
    parameter int BASE_ITEMS     = 4,
    parameter int LEVEL_TIME_SEC = 60
) (
    input  logic                    clk,
    input  logic                    reset,
    level_status_tracker_if.slave   bus
);

    typedef enum logic [2:0] {
        PLAY,
        DIED_WAIT,
        DIED_ACK,
        WIN_WAIT,
        WIN_ACK,
        GAME_OVER
    } state_t;

    state_t     state_q,      state_d;
    logic [1:0] lives_q,      lives_d;
    logic [3:0] items_left_q, items_left_d;
    logic [6:0] time_left_q,  time_left_d;
    logic       bumpy_died_q, bumpy_died_d;
    logic       level_comp_q, level_comp_d;
    logic       zero_lives_q, zero_lives_d;

    logic       die;
    logic [3:0] quota;

    // The quota follows lvl live; it only matters on the PLAY-entry cycle,
    // when the manager has already moved lvl on to the next level.
    assign quota = 4'(BASE_ITEMS) + {1'b0, bus.lvl};

    // State register and all counters. Reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PLAY;
            lives_q      <= 2'(INIT_LIVES);
            items_left_q <= 4'(BASE_ITEMS);
            time_left_q  <= 7'(LEVEL_TIME_SEC);
            bumpy_died_q <= 1'b0;
            level_comp_q <= 1'b0;
            zero_lives_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            items_left_q <= items_left_d;
            time_left_q  <= time_left_d;
            bumpy_died_q <= bumpy_died_d;
            level_comp_q <= level_comp_d;
            zero_lives_q <= zero_lives_d;
        end
    end

    // Next-state logic. Everything holds by default, so outside PLAY the
    // gameplay pulses simply have no effect and the counters freeze.
    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        items_left_d = items_left_q;
        time_left_d  = time_left_q;
        bumpy_died_d = bumpy_died_q;
        level_comp_d = level_comp_q;
        zero_lives_d = zero_lives_q;
        die          = 1'b0;

        case (state_q)
            PLAY: begin
                // Priority: hazard, then completing the quota, then timeout.
                // A non-final item and a tick in the same cycle both count.
                if (bus.hazard_hit) begin
                    die = 1'b1;
                end else if (bus.item_collected && items_left_q == 4'd1) begin
                    items_left_d = 4'd0;
                    level_comp_d = 1'b1;
                    state_d      = WIN_WAIT;
                end else begin
                    if (bus.item_collected && items_left_q > 4'd1) begin
                        items_left_d = items_left_q - 4'd1;
                    end
                    if (bus.one_sec) begin
                        if (time_left_q == 7'd1) begin
                            time_left_d = 7'd0;
                            die         = 1'b1;
                        end else if (time_left_q != 7'd0) begin
                            time_left_d = time_left_q - 7'd1;
                        end
                    end
                end

                // Losing a life saturates at zero; zero_lives rises on the
                // same edge that lives reaches zero.
                if (die) begin
                    state_d      = DIED_WAIT;
                    bumpy_died_d = 1'b1;
                    lives_d      = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                    if (lives_d == 2'd0) begin
                        zero_lives_d = 1'b1;
                    end
                end
            end

            DIED_WAIT: begin
                if (!bus.reset_fsm_N) begin
                    bumpy_died_d = 1'b0;
                    state_d      = DIED_ACK;
                end
            end

            DIED_ACK: begin
                if (bus.reset_fsm_N) begin
                    if (zero_lives_q) begin
                        state_d = GAME_OVER;
                    end else begin
                        state_d      = PLAY;
                        items_left_d = quota;
                        time_left_d  = 7'(LEVEL_TIME_SEC);
                    end
                end
            end

            WIN_WAIT: begin
                if (!bus.reset_fsm_N) begin
                    level_comp_d = 1'b0;
                    state_d      = WIN_ACK;
                end
            end

            WIN_ACK: begin
                if (bus.reset_fsm_N) begin
                    state_d      = PLAY;
                    items_left_d = quota;
                    time_left_d  = 7'(LEVEL_TIME_SEC);
                end
            end

            GAME_OVER: begin
                bumpy_died_d = 1'b0;
                level_comp_d = 1'b0;
            end

            default: begin
                state_d = PLAY;
            end
        endcase
    end

    assign bus.bumpy_died = bumpy_died_q;
    assign bus.level_comp = level_comp_q;
    assign bus.zero_lives = zero_lives_q;
    assign bus.lives      = lives_q;
    assign bus.items_left = items_left_q;
    assign bus.time_left  = time_left_q;

endmodule

// File: tb/tb_level_status_tracker.sv
// ---------------------------------------------------------------------------
// tb_level_status_tracker
//
// Directed, table-driven bench for level_status_tracker. The main instance
// uses default parameters; a second instance with a 3-second countdown
// exercises the timeout-as-death path.
// ---------------------------------------------------------------------------
module tb_level_status_tracker;

    logic clk;
    logic reset;
    logic reset_t;

    int checks;
    int failures;

    level_status_tracker_if bus ();
    level_status_tracker_if bus_t ();

    level_status_tracker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    level_status_tracker #(.LEVEL_TIME_SEC(3)) dut_t (
        .clk   (clk),
        .reset (reset_t),
        .bus   (bus_t.slave)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       haz;
        logic       item;
        logic       tick;
        logic [2:0] lvl;
        logic       rfn;
        logic       exp_bumpy;
        logic       exp_comp;
        logic       exp_zero;
        logic [1:0] exp_lives;
        logic [3:0] exp_items;
        logic [6:0] exp_time;
    } vec_t;

    localparam int NVEC = 32;
    localparam int HOLD_AFTER = 13;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic rst, logic haz, logic item, logic tick,
                                logic [2:0] lvl, logic rfn,
                                logic b, logic c, logic z,
                                logic [1:0] l, logic [3:0] it, logic [6:0] t);
        vec_t v;
        v.rst = rst;  v.haz = haz;  v.item = item; v.tick = tick;
        v.lvl = lvl;  v.rfn = rfn;
        v.exp_bumpy = b; v.exp_comp = c; v.exp_zero = z;
        v.exp_lives = l; v.exp_items = it; v.exp_time = t;
        return v;
    endfunction

    // Drive one cycle of inputs, let one edge pass, settle past the edge.
    task automatic applyStimulus(input vec_t v);
        reset              = v.rst;
        bus.hazard_hit     = v.haz;
        bus.item_collected = v.item;
        bus.one_sec        = v.tick;
        bus.lvl            = v.lvl;
        bus.reset_fsm_N    = v.rfn;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s (step %0d): got %0d, expected %0d",
                     name, idx, actual, expected);
        end
    endtask

    task automatic checkAll(input int idx, input vec_t v);
        checkOutput("bumpy_died", idx, 32'(bus.bumpy_died), 32'(v.exp_bumpy));
        checkOutput("level_comp", idx, 32'(bus.level_comp), 32'(v.exp_comp));
        checkOutput("zero_lives", idx, 32'(bus.zero_lives), 32'(v.exp_zero));
        checkOutput("lives",      idx, 32'(bus.lives),      32'(v.exp_lives));
        checkOutput("items_left", idx, 32'(bus.items_left), 32'(v.exp_items));
        checkOutput("time_left",  idx, 32'(bus.time_left),  32'(v.exp_time));
    endtask

    // Single tick of the short-countdown instance.
    task automatic stepShort(input logic tick, input logic rfn);
        bus_t.one_sec     = tick;
        bus_t.reset_fsm_N = rfn;
        @(posedge clk);
        #1;
        bus_t.one_sec     = 1'b0;
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;

        reset              = 1'b1;
        bus.hazard_hit     = 1'b0;
        bus.item_collected = 1'b0;
        bus.one_sec        = 1'b0;
        bus.lvl            = 3'd0;
        bus.reset_fsm_N    = 1'b1;

        reset_t              = 1'b1;
        bus_t.hazard_hit     = 1'b0;
        bus_t.item_collected = 1'b0;
        bus_t.one_sec        = 1'b0;
        bus_t.lvl            = 3'd0;
        bus_t.reset_fsm_N    = 1'b1;

        //              rst haz itm tck lvl rfn   b  c  z  L  items time
        vecs[0]  = mk(1, 0, 0, 0, 3'd0, 1,  0, 0, 0, 2'd3, 4'd4, 7'd60);
        vecs[1]  = mk(0, 0, 1, 0, 3'd0, 1,  0, 0, 0, 2'd3, 4'd3, 7'd60);
        vecs[2]  = mk(0, 0, 1, 0, 3'd0, 1,  0, 0, 0, 2'd3, 4'd2, 7'd60);
        vecs[3]  = mk(0, 0, 1, 1, 3'd0, 1,  0, 0, 0, 2'd3, 4'd1, 7'd59);
        vecs[4]  = mk(0, 0, 1, 0, 3'd0, 1,  0, 1, 0, 2'd3, 4'd0, 7'd59);
        vecs[5]  = mk(0, 0, 0, 0, 3'd0, 1,  0, 1, 0, 2'd3, 4'd0, 7'd59);
        vecs[6]  = mk(0, 1, 1, 1, 3'd0, 1,  0, 1, 0, 2'd3, 4'd0, 7'd59);
        vecs[7]  = mk(0, 0, 0, 0, 3'd0, 0,  0, 0, 0, 2'd3, 4'd0, 7'd59);
        vecs[8]  = mk(0, 0, 0, 0, 3'd1, 0,  0, 0, 0, 2'd3, 4'd0, 7'd59);
        vecs[9]  = mk(0, 0, 0, 0, 3'd1, 1,  0, 0, 0, 2'd3, 4'd5, 7'd60);
        vecs[10] = mk(0, 0, 1, 1, 3'd1, 0,  0, 0, 0, 2'd3, 4'd4, 7'd59);
        vecs[11] = mk(0, 1, 0, 0, 3'd1, 1,  1, 0, 0, 2'd2, 4'd4, 7'd59);
        vecs[12] = mk(0, 0, 0, 0, 3'd1, 1,  1, 0, 0, 2'd2, 4'd4, 7'd59);
        // ack of the first death, reload at lvl 1
        vecs[13] = mk(0, 0, 0, 0, 3'd1, 0,  0, 0, 0, 2'd2, 4'd4, 7'd59);
        vecs[14] = mk(0, 0, 0, 0, 3'd1, 1,  0, 0, 0, 2'd2, 4'd5, 7'd60);
        // bring items_left to 1, then hazard with the final item
        vecs[15] = mk(0, 0, 1, 0, 3'd1, 1,  0, 0, 0, 2'd2, 4'd4, 7'd60);
        vecs[16] = mk(0, 0, 1, 0, 3'd1, 1,  0, 0, 0, 2'd2, 4'd3, 7'd60);
        vecs[17] = mk(0, 0, 1, 0, 3'd1, 1,  0, 0, 0, 2'd2, 4'd2, 7'd60);
        vecs[18] = mk(0, 0, 1, 0, 3'd1, 1,  0, 0, 0, 2'd2, 4'd1, 7'd60);
        vecs[19] = mk(0, 1, 1, 0, 3'd1, 1,  1, 0, 0, 2'd1, 4'd1, 7'd60);
        vecs[20] = mk(0, 0, 0, 0, 3'd1, 0,  0, 0, 0, 2'd1, 4'd1, 7'd60);
        vecs[21] = mk(0, 0, 0, 0, 3'd1, 1,  0, 0, 0, 2'd1, 4'd5, 7'd60);
        // last life lost with ack already low: event lasts one cycle
        vecs[22] = mk(0, 1, 0, 0, 3'd1, 0,  1, 0, 1, 2'd0, 4'd5, 7'd60);
        vecs[23] = mk(0, 0, 0, 0, 3'd1, 0,  0, 0, 1, 2'd0, 4'd5, 7'd60);
        vecs[24] = mk(0, 0, 0, 0, 3'd1, 1,  0, 0, 1, 2'd0, 4'd5, 7'd60);
        // game over absorbs everything
        vecs[25] = mk(0, 1, 1, 1, 3'd1, 1,  0, 0, 1, 2'd0, 4'd5, 7'd60);
        vecs[26] = mk(0, 0, 0, 0, 3'd1, 0,  0, 0, 1, 2'd0, 4'd5, 7'd60);
        vecs[27] = mk(0, 0, 1, 1, 3'd1, 1,  0, 0, 1, 2'd0, 4'd5, 7'd60);
        // reset restores, then reset in the middle of a death event
        vecs[28] = mk(1, 0, 0, 0, 3'd0, 1,  0, 0, 0, 2'd3, 4'd4, 7'd60);
        vecs[29] = mk(0, 1, 0, 0, 3'd0, 1,  1, 0, 0, 2'd2, 4'd4, 7'd60);
        vecs[30] = mk(1, 0, 0, 0, 3'd0, 1,  0, 0, 0, 2'd3, 4'd4, 7'd60);
        vecs[31] = mk(0, 0, 1, 0, 3'd0, 1,  0, 0, 0, 2'd3, 4'd3, 7'd60);

        for (int i = 0; i < HOLD_AFTER; i++) begin
            applyStimulus(vecs[i]);
            checkAll(i, vecs[i]);
        end

        // Without an ack the death event must stay up.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(vecs[12]);
            checkOutput("bumpy_hold", 100 + k, 32'(bus.bumpy_died), 32'd1);
            checkOutput("lives_hold", 100 + k, 32'(bus.lives),      32'd2);
        end

        for (int i = HOLD_AFTER; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkAll(i, vecs[i]);
        end

        // Countdown expiry on the 3-second instance.
        @(posedge clk);
        #1;
        checkOutput("t_reset_time",  200, 32'(bus_t.time_left), 32'd3);
        checkOutput("t_reset_lives", 200, 32'(bus_t.lives),     32'd3);
        reset_t = 1'b0;
        stepShort(1'b1, 1'b1);
        checkOutput("t_time",  201, 32'(bus_t.time_left),  32'd2);
        checkOutput("t_bumpy", 201, 32'(bus_t.bumpy_died), 32'd0);
        stepShort(1'b1, 1'b1);
        checkOutput("t_time",  202, 32'(bus_t.time_left),  32'd1);
        stepShort(1'b1, 1'b1);
        checkOutput("t_time",  203, 32'(bus_t.time_left),  32'd0);
        checkOutput("t_bumpy", 203, 32'(bus_t.bumpy_died), 32'd1);
        checkOutput("t_lives", 203, 32'(bus_t.lives),      32'd2);
        checkOutput("t_zero",  203, 32'(bus_t.zero_lives), 32'd0);
        stepShort(1'b1, 1'b1);
        checkOutput("t_hold_time", 204, 32'(bus_t.time_left), 32'd0);
        stepShort(1'b0, 1'b0);
        checkOutput("t_ack_bumpy", 205, 32'(bus_t.bumpy_died), 32'd0);
        stepShort(1'b0, 1'b1);
        checkOutput("t_reload_time",  206, 32'(bus_t.time_left),  32'd3);
        checkOutput("t_reload_items", 206, 32'(bus_t.items_left), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
